// File: rtl/hist_tx_pkg.sv
// Shared types and frame geometry for the histogram-builder transmit path.
// Np/PIXEL_NUM/ACQ_NUM/DATA_NUM carry the same values as parametersSiFH.vh for this build.
package hist_tx_pkg;

    localparam int Np        = 10;
    localparam int PIXEL_NUM = 3;
    localparam int ACQ_NUM   = 2;
    localparam int DATA_NUM  = 1;

    localparam int FRAME_WORDS = PIXEL_NUM * ACQ_NUM * DATA_NUM * 2;
    localparam int CNT_W       = $clog2(FRAME_WORDS + 1);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/hist_tx_fifo.sv
// Synchronous show-ahead FIFO; popData is valid whenever !empty.
// Latency 1 cycle push-to-pop; a push while full is taken only if a pop happens on the same edge.
module hist_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic             doPush;
    logic             doPop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (res) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hist_stream_tx.sv
// Streams one frame of TDC words to the histogram builder, optionally followed by a zero flush trailer
// (HIST_TX_FLUSH_EN). Latency: accept at edge k -> wrEn/data after edge k+1. tdcReady drops when FIFO full or frame complete.
module hist_stream_tx
    import hist_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FLUSH_WORDS = 3
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          tdcValid,
    input  logic [Np-1:0] tdcData,
    output logic          tdcReady,
    output logic          wrEn,
    output logic [Np-1:0] data,
    output logic          busy,
    output logic          frameDone
);

    localparam int FCW = (FLUSH_WORDS > 0) ? $clog2(FLUSH_WORDS + 1) : 1;
    localparam logic [FCW-1:0] FLUSH_CNT = FCW'(FLUSH_WORDS);

    state_t          state;
    state_t          nextState;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] emitted;
    logic [FCW-1:0]   flushCnt;
    logic             emitZero;
    logic             fifoPush;
    logic             fifoPop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [Np-1:0]    fifoData;

    assign tdcReady  = (state == STREAM) && !fifoFull && (accepted < FRAME_CNT);
    assign fifoPush  = tdcValid && tdcReady;
    assign fifoPop   = (state == STREAM) && !fifoEmpty;
    assign busy      = (state != IDLE);
    assign frameDone = (state == DONE);

    hist_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (Np)
    ) u_fifo (
        .clk      (clk),
        .res      (res),
        .push     (fifoPush),
        .pushData (tdcData),
        .pop      (fifoPop),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The first trailer word is loaded on the same edge that leaves STREAM so it follows the last frame word directly.
    always_comb begin
        nextState = state;
        emitZero  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = STREAM;
                end
            end
            STREAM: begin
                if (emitted == FRAME_CNT) begin
`ifdef HIST_TX_FLUSH_EN
                    nextState = FLUSH;
                    emitZero  = (flushCnt < FLUSH_CNT);
`else
                    nextState = DONE;
`endif
                end
            end
            FLUSH: begin
                if (flushCnt < FLUSH_CNT) begin
                    emitZero = 1'b1;
                end else begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            accepted <= '0;
            emitted  <= '0;
            flushCnt <= '0;
        end else if (state == IDLE && start) begin
            accepted <= '0;
            emitted  <= '0;
            flushCnt <= '0;
        end else begin
            if (fifoPush) begin
                accepted <= accepted + 1'b1;
            end
            if (fifoPop) begin
                emitted <= emitted + 1'b1;
            end
            if (emitZero) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    // data holds its last value across bubbles; only wrEn marks a real word.
    always_ff @(posedge clk) begin
        if (res) begin
            wrEn <= 1'b0;
            data <= '0;
        end else if (fifoPop) begin
            wrEn <= 1'b1;
            data <= fifoData;
        end else if (emitZero) begin
            wrEn <= 1'b1;
            data <= '0;
        end else begin
            wrEn <= 1'b0;
        end
    end

endmodule
